// File: rtl/key_sync_debounce.sv
// key_sync_debounce: four-key synchronizer and debouncer with press/release pulses
// and a fixed-priority note selector (c5 > ab4 > e4 > c4).
module key_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       c4,
    input  logic       e4,
    input  logic       ab4,
    input  logic       c5,
    output logic       result_c4,
    output logic       result_e4,
    output logic       result_ab4,
    output logic       result_c5,
    output logic       press_c4,
    output logic       press_e4,
    output logic       press_ab4,
    output logic       press_c5,
    output logic       release_c4,
    output logic       release_e4,
    output logic       release_ab4,
    output logic       release_c5,
    output logic [1:0] note_code,
    output logic       note_valid
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [3:0] raw, r, press, rel;
    assign raw = {c5, ab4, e4, c4};
    for (genvar k = 0; k < 4; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync;
        logic [CNT_W-1:0]       cnt;
        logic                   s, r_q, press_q, rel_q;
        assign s = sync[SYNC_STAGES-1];
        // pulses are registered alongside r so they coincide with the level change
        always_ff @(posedge clk_50MHz or posedge reset) begin
            if (reset) begin
                sync    <= '0;
                cnt     <= '0;
                r_q     <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync    <= {sync[SYNC_STAGES-2:0], raw[k]};
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (s == r_q) begin
                    cnt <= '0;
                end else if (cnt < CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt     <= '0;
                    r_q     <= s;
                    press_q <= s;
                    rel_q   <= ~s;
                end
            end
        end
        assign r[k]     = r_q;
        assign press[k] = press_q;
        assign rel[k]   = rel_q;
    end
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            note_code  <= 2'd0;
            note_valid <= 1'b0;
        end else begin
            note_valid <= |r;
            if (|r)
                note_code <= r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
        end
    end
    assign {result_c5, result_ab4, result_e4, result_c4}     = r;
    assign {press_c5, press_ab4, press_e4, press_c4}         = press;
    assign {release_c5, release_ab4, release_e4, release_c4} = rel;
endmodule

// File: doc/key_sync_debounce.md
KEY_SYNC_DEBOUNCE -- requirements
Module: key_sync_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per key, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive disagreeing cycles needed to accept a level change (10 ms at 50 MHz), minimum 2.
REQ-003 SHALL have parameter CNT_W, default 19: debounce counter width, with 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-004 SHALL have port clk_50MHz, input, 1 bit: the single clock; all flops on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports c4, e4, ab4, c5, input, 1 bit each: raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have ports result_c4, result_e4, result_ab4, result_c5, output, 1 bit each: debounced key levels.
REQ-008 SHALL have ports press_c4, press_e4, press_ab4, press_c5, output, 1 bit each: one-cycle press pulses.
REQ-009 SHALL have ports release_c4, release_e4, release_ab4, release_c5, output, 1 bit each: one-cycle release pulses.
REQ-010 SHALL have port note_code, output, 2 bits: selected note; c4=0, e4=1, ab4=2, c5=3.
REQ-011 SHALL have port note_valid, output, 1 bit: 1 while at least one debounced key is high.

Function
REQ-012 Each key SHALL pass through its own SYNC_STAGES-deep flop chain; the last stage is the sample s.
REQ-013 Each key SHALL have its own counter and its own stable level r, which drives result_x.
REQ-014 When s == r, the counter SHALL clear to 0 on the next edge.
REQ-015 When s != r and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When s != r and counter == DEBOUNCE_CYCLES-1, r SHALL take s and the counter SHALL clear on the same edge.
REQ-017 The counter SHALL never wrap, and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-018 Latency: a clean raw change first sampled at edge 1 SHALL change result_x at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-019 A disagreement lasting fewer than DEBOUNCE_CYCLES sampled cycles SHALL leave r unchanged and SHALL clear the counter.
REQ-020 press_x SHALL be 1 exactly in the cycle where result_x first reads 1; otherwise it SHALL be 0.
REQ-021 release_x SHALL be 1 exactly in the cycle where result_x first reads 0; otherwise it SHALL be 0.
REQ-022 press_x and release_x SHALL both be registered, and SHALL never be high at the same time.
REQ-023 The four channels SHALL be independent; simultaneous changes on several keys SHALL each resolve per REQ-014..REQ-016.
REQ-024 note_code and note_valid SHALL be registered from the result levels with 1-cycle latency.
REQ-025 note_code SHALL use fixed priority c5 > ab4 > e4 > c4 among high results.
REQ-026 With no result high, note_valid SHALL be 0 and note_code SHALL hold its last value.
REQ-027 The block SHALL have no combinational path from any input to any output.

Reset
REQ-028 While reset=1, all of the following SHALL be 0, asynchronously: synchronizer flops, counters, r, press/release, note_code, note_valid.
REQ-029 Reset asserted mid-count SHALL discard the partial count.
REQ-030 After reset release, a key held high SHALL be accepted only after the full latency of REQ-018, with a press pulse.
REQ-031 Reset release SHALL generate no press or release pulse by itself.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4; raw inputs driven at the falling edge)
REQ-032 Clean press: c4 0->1, held -> result_c4=1 and press_c4=1 at edge 6; press_c4=0 at edge 7; note_code=0 and note_valid=1 at edge 7.
REQ-033 Glitch: e4 high for exactly 3 sampled edges, then low -> result_e4 stays 0, no pulses; with 4 edges -> result_e4=1 at edge 6.
REQ-034 Priority: e4 and c5 pressed together -> both results rise at the same edge; note_code=3 one edge later; release c5 -> note_code=1 after debounce+1.
REQ-035 Release: all keys released -> release pulses one cycle each; note_valid=0; note_code holds its last value.
REQ-036 Bounce: ab4 toggled every 2 cycles for 40 cycles, then held high -> no pulses during toggling; exactly one press_ab4 DEBOUNCE_CYCLES+2 edges after the final rise.
REQ-037 Reset mid-count: reset pulsed when c5's counter=2 with c5 held -> all outputs 0 during reset; result_c5 rises 6 edges after reset release.
